// File: rtl/pu_msp430_enc_pkg.sv
// Shared types and constants for the MSP430 instruction encoder.
// Instruction-type and FSM-state enums, fixed opcode fields, illegal check.
package pu_msp430_enc_pkg;

    typedef enum logic [1:0] {
        T_SIG = 2'd0,
        T_JMP = 2'd1,
        T_TWO = 2'd2,
        T_ILL = 2'd3
    } inst_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPC  = 2'd1,
        S_SRC  = 2'd2,
        S_DST  = 2'd3
    } enc_state_e;

    localparam logic [15:0] OP_RETI    = 16'h1300;
    localparam logic [5:0]  SIG_PREFIX = 6'b000100;
    localparam logic [2:0]  JMP_PREFIX = 3'b001;
    localparam logic [2:0]  SIG_SWPB   = 3'd1;
    localparam logic [2:0]  SIG_SXT    = 3'd3;
    localparam logic [2:0]  SIG_CALL   = 3'd5;
    localparam logic [2:0]  SIG_RETI   = 3'd6;
    localparam logic [2:0]  SIG_BAD    = 3'd7;

    function automatic logic enc_illegal(inst_type_e t, logic [3:0] op);
        return (t == T_ILL)
            || (t == T_TWO && op < 4'd4)
            || (t == T_SIG && op[2:0] == SIG_BAD);
    endfunction

endpackage

// File: rtl/pu_msp430_inst_encoder_pack.sv
// Combinational opcode packer: descriptor fields -> opcode word.
// Ports: registered descriptor in; opc_word, need_src, need_dst, illegal out.
module pu_msp430_inst_pack
    import pu_msp430_enc_pkg::*;
(
    input  inst_type_e  typ,
    input  logic [3:0]  op,
    input  logic        bw,
    input  logic [3:0]  src_reg,
    input  logic [1:0]  as_mode,
    input  logic [3:0]  dst_reg,
    input  logic        ad,
    input  logic [9:0]  jmp_off,
    output logic [15:0] opc_word,
    output logic        need_src,
    output logic        need_dst,
    output logic        illegal
);

    logic [2:0] sop;
    logic       src_ext;
    logic       bw_eff;

    always_comb begin
        sop      = op[2:0];
        // R3 and R2 in modes 10/11 are constant generators: no word.
        src_ext  = (as_mode == 2'b01 && src_reg != 4'd3)
                || (as_mode == 2'b11 && src_reg == 4'd0);
        bw_eff   = bw && !(sop == SIG_SWPB || sop == SIG_SXT
                        || sop == SIG_CALL);
        opc_word = 16'h0000;
        need_src = 1'b0;
        need_dst = 1'b0;
        illegal  = enc_illegal(typ, op);
        unique case (typ)
            T_TWO: begin
                opc_word = {op, src_reg, ad, bw, as_mode, dst_reg};
                need_src = src_ext;
                need_dst = ad;
            end
            T_SIG: begin
                if (sop == SIG_RETI) begin
                    opc_word = OP_RETI;
                end else begin
                    opc_word = {SIG_PREFIX, sop, bw_eff, as_mode, src_reg};
                    need_src = src_ext;
                end
            end
            T_JMP: opc_word = {JMP_PREFIX, sop, jmp_off};
            default: opc_word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/pu_msp430_inst_encoder.sv
// MSP430 instruction encoder: descriptor in, opcode + extension words out.
// Ports: req_* descriptor handshake, word_* stream, enc_err, inst_count.
module pu_msp430_inst_encoder
    import pu_msp430_enc_pkg::*;
(
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [3:0]  req_op,
    input  logic        req_bw,
    input  logic [3:0]  req_src_reg,
    input  logic [1:0]  req_as,
    input  logic [3:0]  req_dst_reg,
    input  logic        req_ad,
    input  logic [9:0]  req_jmp_off,
    input  logic [15:0] req_src_ext,
    input  logic [15:0] req_dst_ext,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] word_data,
    output logic        word_last,
    output logic        enc_err,
    output logic [15:0] inst_count
);

    enc_state_e  state, state_nxt;
    inst_type_e  d_type;
    logic [3:0]  d_op, d_src, d_dst;
    logic        d_bw, d_ad, err_q;
    logic [1:0]  d_as;
    logic [9:0]  d_off;
    logic [15:0] d_sext, d_dext;
    logic [15:0] opc_word;
    logic        need_src, need_dst, illegal;
    logic        accept, req_bad;

    assign accept  = (state == S_IDLE) && req_valid;
    assign req_bad = enc_illegal(inst_type_e'(req_type), req_op);

    pu_msp430_inst_pack u_pack (
        .typ      (d_type),
        .op       (d_op),
        .bw       (d_bw),
        .src_reg  (d_src),
        .as_mode  (d_as),
        .dst_reg  (d_dst),
        .ad       (d_ad),
        .jmp_off  (d_off),
        .opc_word (opc_word),
        .need_src (need_src),
        .need_dst (need_dst),
        .illegal  (illegal)
    );

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= S_IDLE;
            d_type     <= T_SIG;
            d_op       <= '0;
            d_bw       <= 1'b0;
            d_src      <= '0;
            d_as       <= '0;
            d_dst      <= '0;
            d_ad       <= 1'b0;
            d_off      <= '0;
            d_sext     <= '0;
            d_dext     <= '0;
            err_q      <= 1'b0;
            inst_count <= '0;
        end else begin
            state <= state_nxt;
            err_q <= accept;
            if (accept) begin
                d_type <= inst_type_e'(req_type);
                d_op   <= req_op;
                d_bw   <= req_bw;
                d_src  <= req_src_reg;
                d_as   <= req_as;
                d_dst  <= req_dst_reg;
                d_ad   <= req_ad;
                d_off  <= req_jmp_off;
                d_sext <= req_src_ext;
                d_dext <= req_dst_ext;
                if (!req_bad) inst_count <= inst_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (req_valid) state_nxt = req_bad ? S_IDLE : S_OPC;
            S_OPC: if (word_ready)
                state_nxt = need_src ? S_SRC : (need_dst ? S_DST : S_IDLE);
            S_SRC: if (word_ready) state_nxt = need_dst ? S_DST : S_IDLE;
            S_DST: if (word_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        word_valid = (state != S_IDLE);
        // err_q marks the cycle after any acceptance; the captured
        // fields tell whether that descriptor was the illegal one.
        enc_err    = err_q && illegal;
        word_data  = 16'h0000;
        word_last  = 1'b0;
        unique case (state)
            S_OPC: begin
                word_data = opc_word;
                word_last = !need_src && !need_dst;
            end
            S_SRC: begin
                word_data = d_sext;
                word_last = !need_dst;
            end
            S_DST: begin
                word_data = d_dext;
                word_last = 1'b1;
            end
            default: begin
                word_data = 16'h0000;
                word_last = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pu_msp430_inst_encoder.sv
// Scoreboard bench for pu_msp430_inst_encoder.
// Directed test-plan cases, reset mid-instruction, then random descriptors.
module tb_pu_msp430_inst_encoder;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = '0;
    logic [3:0]  req_op = '0;
    logic        req_bw = 1'b0;
    logic [3:0]  req_src_reg = '0;
    logic [1:0]  req_as = '0;
    logic [3:0]  req_dst_reg = '0;
    logic        req_ad = 1'b0;
    logic [9:0]  req_jmp_off = '0;
    logic [15:0] req_src_ext = '0;
    logic [15:0] req_dst_ext = '0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_last;
    logic        enc_err;
    logic [15:0] inst_count;

    pu_msp430_inst_encoder dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_op      (req_op),
        .req_bw      (req_bw),
        .req_src_reg (req_src_reg),
        .req_as      (req_as),
        .req_dst_reg (req_dst_reg),
        .req_ad      (req_ad),
        .req_jmp_off (req_jmp_off),
        .req_src_ext (req_src_ext),
        .req_dst_ext (req_dst_ext),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_data   (word_data),
        .word_last   (word_last),
        .enc_err     (enc_err),
        .inst_count  (inst_count)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    logic [15:0] cnt_model = 16'h0000;
    int          ready_mode = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int d, input int l);
        exp_t e;
        e.d = d[15:0];
        e.l = l[0];
        exp_q.push_back(e);
    endtask

    // Reference model: words of one instruction from the mnemonic rules.
    task automatic model(input int t, input int op, input int bw,
                         input int sr, input int as, input int dr,
                         input int ad, input int off,
                         input int se, input int de);
        int w, bwe, sop;
        bit s, d;
        sop = op % 8;
        if (t == 3 || (t == 2 && op < 4) || (t == 0 && sop == 7)) begin
            err_exp++;
            return;
        end
        cnt_model = cnt_model + 16'd1;
        if (t == 1) begin
            push_exp('h2000 + sop * 1024 + off, 1);
            return;
        end
        if (t == 0 && sop == 6) begin
            push_exp('h1300, 1);
            return;
        end
        if (t == 2) begin
            w = op * 4096 + sr * 256 + ad * 128 + bw * 64 + as * 16 + dr;
        end else begin
            bwe = (sop == 1 || sop == 3 || sop == 5) ? 0 : bw;
            w = 'h1000 + sop * 128 + bwe * 64 + as * 16 + sr;
        end
        s = (as == 1 && sr != 3) || (as == 3 && sr == 0);
        d = (t == 2) && (ad == 1);
        push_exp(w, (!s && !d) ? 1 : 0);
        if (s) push_exp(se, d ? 0 : 1);
        if (d) push_exp(de, 1);
    endtask

    task automatic send(input int t, input int op, input int bw,
                        input int sr, input int as, input int dr,
                        input int ad, input int off,
                        input int se, input int de);
        @(posedge mclk);
        #1;
        req_valid   = 1'b1;
        req_type    = t[1:0];
        req_op      = op[3:0];
        req_bw      = bw[0];
        req_src_reg = sr[3:0];
        req_as      = as[1:0];
        req_dst_reg = dr[3:0];
        req_ad      = ad[0];
        req_jmp_off = off[9:0];
        req_src_ext = se[15:0];
        req_dst_ext = de[15:0];
        model(t, op, bw, sr, as, dr, ad, off, se, de);
        @(posedge mclk);
        #1;
        req_valid   = 1'b0;
        req_type    = 2'($urandom);
        req_op      = 4'($urandom);
        req_src_reg = 4'($urandom);
        req_as      = 2'($urandom);
        req_src_ext = 16'($urandom);
        req_dst_ext = 16'($urandom);
        req_jmp_off = 10'($urandom);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        do begin
            @(negedge mclk);
            #1;
            k++;
        end while (k < 2 || ((exp_q.size() != 0 || !req_ready) && k < 300));
        if (k >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: %0d words outstanding", name,
                     exp_q.size());
        end
        check({name, " inst_count"}, int'(inst_count), int'(cnt_model));
        check({name, " enc_err pulses"}, err_seen, err_exp);
    endtask

    task automatic check_reset(input string name);
        check({name, " req_ready"}, int'(req_ready), 1);
        check({name, " word_valid"}, int'(word_valid), 0);
        check({name, " word_data"}, int'(word_data), 0);
        check({name, " word_last"}, int'(word_last), 0);
        check({name, " enc_err"}, int'(enc_err), 0);
        check({name, " inst_count"}, int'(inst_count), 0);
    endtask

    initial begin
        forever begin
            @(posedge mclk);
            #1;
            case (ready_mode)
                0: word_ready = 1'b1;
                1: word_ready = 1'($urandom_range(0, 1));
                2: word_ready = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin
        exp_t        e;
        logic        stall;
        logic [15:0] hd;
        logic        hl;
        stall = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge mclk);
            if (!puc_rst_n) begin
                stall = 1'b0;
            end else begin
                if (enc_err) err_seen++;
                if (stall) begin
                    n_cmp++;
                    if (!word_valid || word_data !== hd || word_last !== hl) begin
                        n_bad++;
                        $display("FAIL hold: got v%0b %0h l%0b, expected v1 %0h l%0b",
                                 word_valid, word_data, word_last, hd, hl);
                    end
                end
                if (word_valid && word_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL word: got unexpected %0h, expected none",
                                 word_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (word_data !== e.d || word_last !== e.l) begin
                            n_bad++;
                            $display("FAIL word: got %0h last %0b, expected %0h last %0b",
                                     word_data, word_last, e.d, e.l);
                        end
                    end
                end
                stall = word_valid && !word_ready;
                hd = word_data;
                hl = word_last;
            end
        end
    end

    initial begin
        #1;
        check_reset("reset");
        repeat (3) @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;

        send(2, 4, 0, 0, 3, 2, 1, 0, 'h1234, 'h0200);
        drain("mov_imm_abs");
        check("mov count is 1", int'(inst_count), 1);
        send(0, 4, 1, 5, 0, 0, 0, 0, 'hAAAA, 'hBBBB);
        drain("push_b");
        send(0, 5, 1, 0, 3, 0, 0, 0, 'h4400, 'h0);
        drain("call_imm");
        send(1, 7, 0, 0, 0, 0, 0, 'h3FF, 0, 0);
        drain("jmp");
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("jne");
        send(0, 6, 1, 9, 2, 7, 1, 'h155, 'h1111, 'h2222);
        drain("reti");
        send(2, 2, 0, 4, 1, 5, 1, 0, 1, 2);
        send(0, 7, 0, 4, 1, 5, 0, 0, 1, 2);
        drain("illegal");

        ready_mode = 2;
        send(2, 4, 0, 3, 1, 3, 0, 0, 'hDEAD, 'hBEEF);
        repeat (6) @(posedge mclk);
        ready_mode = 0;
        drain("mov_cg_stall");

        ready_mode = 3;
        word_ready = 1'b0;
        send(2, 4, 0, 0, 3, 2, 1, 0, 'h5555, 'h0300);
        @(posedge mclk);
        #1;
        word_ready = 1'b1;
        @(posedge mclk);
        #1;
        word_ready = 1'b0;
        #2;
        exp_q.delete();
        puc_rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        cnt_model = 16'h0000;
        @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        ready_mode = 0;
        send(0, 0, 1, 6, 1, 0, 0, 0, 'h0042, 0);
        drain("after_reset");

        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int t, op;
            t = $urandom_range(0, 3);
            op = (t == 2 || t == 3) ? $urandom_range(0, 15)
                                    : $urandom_range(0, 7);
            send(t, op, $urandom_range(0, 1), $urandom_range(0, 15),
                 $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 1023),
                 $urandom_range(0, 65535), $urandom_range(0, 65535));
            drain("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
